multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle main decoder.
- Sequences each RV32I instruction through FETCH/DECODE/EXEC/MEM/WB over several clocks instead of decoding it in one combinational pass.
- Drives the shared-ALU/single-memory datapath through a req/ready memory handshake, with a bounded-wait timeout.
- Also provides an illegal-opcode fault and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 16: maximum wait cycles on mem_ready before fault. 0 disables the timeout.
- CNT_W, 32: width of instret counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- en  in  1  run enable; sampled only at instruction boundaries
- instr  in  32  IR contents; opcode = instr[6:2]
- mem_ready  in  1  memory completes the current request this cycle
- branch_taken  in  1  ALU compare result, valid in EXEC for branches
- fault_clr  in  1  clears FAULT state
- mem_req  out  1  memory request
- mem_we  out  1  store when mem_req=1
- adr_src  out  1  0=PC, 1=ALUOut
- ir_write  out  1  latch IR (and OLDPC)
- pc_write  out  1  update PC
- pc_src  out  1  0=ALU result, 1=ALUOut
- reg_write  out  1  register-file write
- alu_src_a  out  2  00=PC, 01=OLDPC, 10=rs1
- alu_src_b  out  2  00=rs2, 01=imm, 10=const 4
- alu_op  out  2  00=add, 01=branch compare, 10=R-type funct, 11=I-type funct
- result_src  out  2  00=ALUOut, 01=mem data, 10=PC (link), 11=imm (LUI)
- illegal  out  1  sticky: unknown opcode
- timeout  out  1  sticky: memory wait exceeded
- retire  out  1  one-cycle pulse per completed instruction
- instret  out  CNT_W  retired count; wraps modulo 2^CNT_W
- state_dbg  out  3  current state encoding

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT.
  - Reset enters IDLE asynchronously.
  - Reset clears instret, illegal, timeout, the wait counter and the latched class.
- Outputs are combinational from state, latched class and inputs. Every strobe is 0 in IDLE, FAULT and during reset.
- IDLE: go to FETCH when en=1.
- FETCH: mem_req=1, adr_src=0.
  - When mem_ready: ir_write=1, pc_write=1, pc_src=0, a=PC, b=4, alu_op=00; go to DECODE.
- DECODE: classify instr[6:2] and latch the class.
  - Always present a=OLDPC, b=imm, alu_op=00 (target into ALUOut).
  - Unknown opcode: set illegal, go to FAULT.
  - Otherwise go to EXEC.
- EXEC, per class:
  - R (01100): a=rs1, b=rs2, op=10; go to WB.
  - I-ALU (00100): a=rs1, b=imm, op=11; go to WB.
  - LOAD (00000) / STORE (01000): a=rs1, b=imm, op=00; go to MEM.
  - BRANCH (11000): a=rs1, b=rs2, op=01. pc_write=branch_taken, pc_src=1. Retire.
  - JAL (11011): pc_write=1, pc_src=1; go to WB.
  - JALR (11001): a=rs1, b=imm, op=00, pc_write=1, pc_src=0; go to WB.
  - LUI (01101): go to WB.
  - AUIPC (00101): a=OLDPC, b=imm, op=00; go to WB.
- MEM: mem_req=1, adr_src=1, mem_we=(class==STORE).
  - On mem_ready: LOAD goes to WB; STORE retires.
- WB: reg_write=1; retire.
  - result_src: 01 for LOAD, 10 for JAL/JALR, 11 for LUI, 00 otherwise.
- Retire:
  - retire=1 and instret+1 in that cycle.
  - Next state is FETCH if en=1, else IDLE.
  - en falling mid-instruction never aborts the instruction.
- Latency (zero-wait memory): R/I/LUI/AUIPC/JAL/JALR 4 cycles, load 5, store 4, branch 3.
- Timeout:
  - The wait counter clears on entering FETCH or MEM.
  - It increments each cycle with mem_req=1 and mem_ready=0.
  - If it reaches MEM_TIMEOUT with ready still low, set timeout and go to FAULT.
  - mem_ready on the limit cycle wins; no fault.
- FAULT: holds all strobes low. fault_clr=1 clears both sticky flags and goes to IDLE. rst has priority over everything.
- Reset mid-operation abandons the instruction with no retire; instret is not incremented.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum
  - 5-bit opcode constants
  - class enum: R, IALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, ILLEGAL
  - alu_src_a/b, alu_op, result_src codes
- Sub-module opcode_classify: combinational, instr[6:2] to class.

Test Plan:
- Reset, en=1, R-type 0x002081B3, mem_ready=1 always -> states IDLE,FETCH,DECODE,EXEC,WB; reg_write=1 in WB with result_src=00; retire at cycle 5; instret=1.
- Load 0x0000A183, mem_ready low 3 cycles in MEM -> mem_req held 4 cycles, mem_we=0; WB result_src=01; no fault.
- Store 0x0020A023 -> MEM mem_we=1, adr_src=1; retire from MEM; reg_write never asserted.
- Branch 0x00208463 with branch_taken=0, then 1 -> pc_write 0, then 1 with pc_src=1; 3 cycles each.
- Opcode 7'b1111111 -> illegal=1, FAULT, strobes 0; fault_clr -> IDLE, flags 0.
- MEM_TIMEOUT=16, mem_ready never in FETCH -> timeout=1 after 16 wait cycles. Ready on cycle 16 -> no fault. Async rst mid-MEM -> IDLE immediately, instret unchanged.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// riscv_ctrl_pkg: shared types and codes for the multi-cycle RV32I controller.
// Revision 1.0
// ============================================================================
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    CLS_R       = 4'd0,
    CLS_IALU    = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_JALR    = 4'd6,
    CLS_LUI     = 4'd7,
    CLS_AUIPC   = 4'd8,
    CLS_ILLEGAL = 4'd9
  } instr_class_e;

  // instr[6:2] values
  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_IALU   = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2   = 2'b00;
  localparam logic [1:0] SRC_B_IMM   = 2'b01;
  localparam logic [1:0] SRC_B_FOUR  = 2'b10;

  localparam logic [1:0] ALU_ADD     = 2'b00;
  localparam logic [1:0] ALU_BRANCH  = 2'b01;
  localparam logic [1:0] ALU_RTYPE   = 2'b10;
  localparam logic [1:0] ALU_ITYPE   = 2'b11;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEM     = 2'b01;
  localparam logic [1:0] RES_PC      = 2'b10;
  localparam logic [1:0] RES_IMM     = 2'b11;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// multicycle_control_if: controller <-> datapath/memory control bundle.
// Revision 1.0
// ============================================================================
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic             en;
  logic [31:0]      instr;
  logic             mem_ready;
  logic             branch_taken;
  logic             fault_clr;
  logic             mem_req;
  logic             mem_we;
  logic             adr_src;
  logic             ir_write;
  logic             pc_write;
  logic             pc_src;
  logic             reg_write;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       result_src;
  logic             illegal;
  logic             timeout;
  logic             retire;
  logic [CNT_W-1:0] instret;
  logic [2:0]       state_dbg;

  modport master (
    input  en, instr, mem_ready, branch_taken, fault_clr,
    output mem_req, mem_we, adr_src, ir_write, pc_write, pc_src, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src,
           illegal, timeout, retire, instret, state_dbg
  );

  modport slave (
    output en, instr, mem_ready, branch_taken, fault_clr,
    input  mem_req, mem_we, adr_src, ir_write, pc_write, pc_src, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src,
           illegal, timeout, retire, instret, state_dbg
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_opcode_classify.sv
`default_nettype none
// ============================================================================
// opcode_classify: maps RV32I instr[6:2] to an instruction class.
// Revision 1.0
// ============================================================================
module opcode_classify
  import riscv_ctrl_pkg::*;
(
  input  logic [4:0]   opcode,
  output instr_class_e cls
);

  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      OP_R:      cls = CLS_R;
      OP_IALU:   cls = CLS_IALU;
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
      OP_BRANCH: cls = CLS_BRANCH;
      OP_JAL:    cls = CLS_JAL;
      OP_JALR:   cls = CLS_JALR;
      OP_LUI:    cls = CLS_LUI;
      OP_AUIPC:  cls = CLS_AUIPC;
      default:   cls = CLS_ILLEGAL;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I datapath.
// Revision 1.0
// ============================================================================
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            r_state;
  state_e            w_state_next;
  instr_class_e      r_cls;
  instr_class_e      w_cls;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0]  r_instret;
  logic              r_illegal;
  logic              r_timeout;
  logic              w_retire;
  logic              w_set_illegal;
  logic              w_set_timeout;
  logic              w_wait_limit;
  logic              w_unused_instr;

  opcode_classify u_classify (
    .opcode (bus.instr[6:2]),
    .cls    (w_cls)
  );

  assign w_unused_instr = ^{bus.instr[31:7], bus.instr[1:0]};
  // Last permitted wait cycle: a ready here still completes the request.
  assign w_wait_limit   = (MEM_TIMEOUT != 0) && (r_wait_cnt == WAIT_LAST);

  assign bus.illegal   = r_illegal;
  assign bus.timeout   = r_timeout;
  assign bus.retire    = w_retire;
  assign bus.instret   = r_instret;
  assign bus.state_dbg = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cls      <= CLS_R;
      r_wait_cnt <= '0;
      r_instret  <= '0;
      r_illegal  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (r_state == ST_DECODE) begin
        r_cls <= w_cls;
      end
      // Non-waiting cycles (including those before FETCH/MEM) zero the counter.
      if (bus.mem_req && !bus.mem_ready) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
      if (w_retire) begin
        r_instret <= r_instret + 1'b1;
      end
      if ((r_state == ST_FAULT) && bus.fault_clr) begin
        r_illegal <= 1'b0;
        r_timeout <= 1'b0;
      end else begin
        if (w_set_illegal) r_illegal <= 1'b1;
        if (w_set_timeout) r_timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_retire       = 1'b0;
    w_set_illegal  = 1'b0;
    w_set_timeout  = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.adr_src    = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = SRC_A_PC;
    bus.alu_src_b  = SRC_B_RS2;
    bus.alu_op     = ALU_ADD;
    bus.result_src = RES_ALUOUT;

    case (r_state)
      ST_IDLE: begin
        if (bus.en) w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_write  = 1'b1;
          bus.pc_write  = 1'b1;
          bus.alu_src_b = SRC_B_FOUR;
          w_state_next  = ST_DECODE;
        end else if (w_wait_limit) begin
          w_set_timeout = 1'b1;
          w_state_next  = ST_FAULT;
        end
      end
      ST_DECODE: begin
        bus.alu_src_a = SRC_A_OLDPC;
        bus.alu_src_b = SRC_B_IMM;
        if (w_cls == CLS_ILLEGAL) begin
          w_set_illegal = 1'b1;
          w_state_next  = ST_FAULT;
        end else begin
          w_state_next  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_state_next = ST_WB;
        case (r_cls)
          CLS_R: begin
            bus.alu_src_a = SRC_A_RS1;
            bus.alu_op    = ALU_RTYPE;
          end
          CLS_IALU: begin
            bus.alu_src_a = SRC_A_RS1;
            bus.alu_src_b = SRC_B_IMM;
            bus.alu_op    = ALU_ITYPE;
          end
          CLS_LOAD, CLS_STORE: begin
            bus.alu_src_a = SRC_A_RS1;
            bus.alu_src_b = SRC_B_IMM;
            w_state_next  = ST_MEM;
          end
          CLS_BRANCH: begin
            bus.alu_src_a = SRC_A_RS1;
            bus.alu_op    = ALU_BRANCH;
            bus.pc_write  = bus.branch_taken;
            bus.pc_src    = 1'b1;
            w_retire      = 1'b1;
          end
          CLS_JAL: begin
            bus.pc_write = 1'b1;
            bus.pc_src   = 1'b1;
          end
          CLS_JALR: begin
            bus.alu_src_a = SRC_A_RS1;
            bus.alu_src_b = SRC_B_IMM;
            bus.pc_write  = 1'b1;
          end
          CLS_AUIPC: begin
            bus.alu_src_a = SRC_A_OLDPC;
            bus.alu_src_b = SRC_B_IMM;
          end
          CLS_LUI: ;
          default: w_state_next = ST_IDLE;
        endcase
      end
      ST_MEM: begin
        bus.mem_req = 1'b1;
        bus.adr_src = 1'b1;
        bus.mem_we  = (r_cls == CLS_STORE);
        if (bus.mem_ready) begin
          if (r_cls == CLS_STORE) w_retire     = 1'b1;
          else                    w_state_next = ST_WB;
        end else if (w_wait_limit) begin
          w_set_timeout = 1'b1;
          w_state_next  = ST_FAULT;
        end
      end
      ST_WB: begin
        bus.reg_write = 1'b1;
        w_retire      = 1'b1;
        case (r_cls)
          CLS_LOAD:           bus.result_src = RES_MEM;
          CLS_JAL, CLS_JALR:  bus.result_src = RES_PC;
          CLS_LUI:            bus.result_src = RES_IMM;
          default:            bus.result_src = RES_ALUOUT;
        endcase
      end
      ST_FAULT: begin
        if (bus.fault_clr) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase

    // en is only consulted at the boundary, so dropping it never aborts work.
    if (w_retire) begin
      w_state_next = bus.en ? ST_FETCH : ST_IDLE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// Randomized and directed bench for multicycle_control against a per-instruction
// latency/strobe-count model derived from the instruction class rules.
module tb_multicycle_control;
  import riscv_ctrl_pkg::*;

  typedef struct packed {
    logic [7:0] cycles;
    logic [7:0] mem_req_cyc;
    logic [7:0] mem_we_cyc;
    logic [7:0] we_adr_cyc;
    logic [3:0] reg_write_cyc;
    logic [3:0] pc_write_cyc;
    logic [3:0] ir_write_cyc;
    logic [3:0] retires;
    logic [1:0] res_src;
    logic       pc_src_last;
    logic       fault;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_instret = '0;

  multicycle_control_if #(.CNT_W(32)) bus ();

  multicycle_control #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t model(logic [31:0] ins, int fw, int mw, logic bt);
    obs_t e;
    logic [4:0] op;
    bit ld, st, br, jal, jalr, mem;
    op   = ins[6:2];
    ld   = (op == 5'b00000);
    st   = (op == 5'b01000);
    br   = (op == 5'b11000);
    jal  = (op == 5'b11011);
    jalr = (op == 5'b11001);
    mem  = ld || st;
    e = '0;
    e.cycles        = 8'((br ? 3 : (ld ? 5 : 4)) + fw + (mem ? mw : 0));
    e.mem_req_cyc   = 8'(fw + 1 + (mem ? mw + 1 : 0));
    e.mem_we_cyc    = 8'(st ? mw + 1 : 0);
    e.we_adr_cyc    = e.mem_we_cyc;
    e.reg_write_cyc = (br || st) ? 4'd0 : 4'd1;
    e.pc_write_cyc  = 4'(1 + ((jal || jalr) ? 1 : 0) + ((br && bt) ? 1 : 0));
    e.ir_write_cyc  = 4'd1;
    e.retires       = 4'd1;
    e.res_src       = ld ? 2'b01 : ((jal || jalr) ? 2'b10 : ((op == 5'b01101) ? 2'b11 : 2'b00));
    e.pc_src_last   = jal || (br && bt);
    e.fault         = 1'b0;
    return e;
  endfunction

  // Runs one instruction starting in FETCH; memory answers after fw/mw wait cycles.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                           input logic bt, input logic drop_en, output obs_t o);
    int fcnt, mcnt;
    bit done;
    o = '0; fcnt = 0; mcnt = 0; done = 0;
    for (int c = 0; c < 80 && !done; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        bus.instr = ins;
        bus.branch_taken = bt;
        if (drop_en) bus.en = 1'b0;
      end
      bus.mem_ready = 1'b0;
      if (bus.mem_req) begin
        if (!bus.adr_src) begin
          bus.mem_ready = (fcnt >= fw);
          if (fcnt < fw) fcnt++;
        end else begin
          bus.mem_ready = (mcnt >= mw);
          if (mcnt < mw) mcnt++;
        end
      end
      @(negedge clk);
      o.cycles = o.cycles + 8'd1;
      if (bus.mem_req) o.mem_req_cyc = o.mem_req_cyc + 8'd1;
      if (bus.mem_we) o.mem_we_cyc = o.mem_we_cyc + 8'd1;
      if (bus.mem_we && bus.adr_src) o.we_adr_cyc = o.we_adr_cyc + 8'd1;
      if (bus.ir_write) o.ir_write_cyc = o.ir_write_cyc + 4'd1;
      if (bus.reg_write) begin
        o.reg_write_cyc = o.reg_write_cyc + 4'd1;
        o.res_src = bus.result_src;
      end
      if (bus.pc_write) begin
        o.pc_write_cyc = o.pc_write_cyc + 4'd1;
        o.pc_src_last = bus.pc_src;
      end
      if (bus.illegal || bus.timeout) o.fault = 1'b1;
      if (bus.retire) begin
        o.retires = o.retires + 4'd1;
        done = 1;
      end
    end
  endtask

  task automatic idle_kick(input logic [31:0] ins);
    @(posedge clk); #1;
    bus.en = 1'b1;
    bus.instr = ins;
    bus.mem_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d want=%0d", bus.state_dbg, ST_IDLE); end
    checks++;
    if (bus.instret !== 32'd0) begin errors++; $display("FAIL reset_instret got=%0d want=0", bus.instret); end
    checks++;
    if ({bus.illegal, bus.timeout} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b want=00", {bus.illegal, bus.timeout}); end
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write, bus.reg_write, bus.retire} !== 6'b0) begin
      errors++; $display("FAIL reset_strobes got=%b want=000000",
        {bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write, bus.reg_write, bus.retire});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.en = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.state_dbg !== ST_IDLE) begin errors++; $display("FAIL idle_hold got=%0d want=%0d", bus.state_dbg, ST_IDLE); end
  endtask

  task automatic test_rtype_sequence;
    state_e exp_st [5];
    exp_st = '{ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_WB};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin bus.en = 1'b1; bus.instr = 32'h002081B3; bus.mem_ready = 1'b1; end
      if (i == 2) bus.en = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.state_dbg !== exp_st[i]) begin errors++; $display("FAIL rtype_state[%0d] got=%0d want=%0d", i, bus.state_dbg, exp_st[i]); end
    end
    checks++;
    if ({bus.reg_write, bus.result_src, bus.retire} !== 4'b1001) begin
      errors++; $display("FAIL rtype_wb got=%b want=1001", {bus.reg_write, bus.result_src, bus.retire});
    end
    exp_instret++;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.instret !== exp_instret || bus.state_dbg !== ST_IDLE) begin
      errors++; $display("FAIL rtype_after instret=%0d state=%0d want instret=%0d state=%0d",
        bus.instret, bus.state_dbg, exp_instret, ST_IDLE);
    end
  endtask

  task automatic test_load_wait;
    obs_t o, e;
    idle_kick(32'h0000A183);
    run_instr(32'h0000A183, 0, 3, 1'b0, 1'b1, o);
    e = model(32'h0000A183, 0, 3, 1'b0);
    checks++;
    if (o !== e) begin errors++; $display("FAIL load_wait got=%h want=%h", o, e); end
    checks++;
    if (o.mem_req_cyc !== 8'd5 || o.res_src !== 2'b01) begin
      errors++; $display("FAIL load_literal mem_req=%0d res=%b want 5/01", o.mem_req_cyc, o.res_src);
    end
    exp_instret++;
  endtask

  task automatic test_store;
    obs_t o, e;
    idle_kick(32'h0020A023);
    run_instr(32'h0020A023, 1, 0, 1'b0, 1'b1, o);
    e = model(32'h0020A023, 1, 0, 1'b0);
    checks++;
    if (o !== e) begin errors++; $display("FAIL store got=%h want=%h", o, e); end
    checks++;
    if (o.we_adr_cyc !== 8'd1 || o.reg_write_cyc !== 4'd0) begin
      errors++; $display("FAIL store_literal we_adr=%0d reg_write=%0d want 1/0", o.we_adr_cyc, o.reg_write_cyc);
    end
    exp_instret++;
  endtask

  task automatic test_branch;
    obs_t o, e;
    idle_kick(32'h00208463);
    for (int t = 0; t < 2; t++) begin
      run_instr(32'h00208463, 0, 0, t[0], t == 1, o);
      e = model(32'h00208463, 0, 0, t[0]);
      checks++;
      if (o !== e) begin errors++; $display("FAIL branch[%0d] got=%h want=%h", t, o, e); end
      checks++;
      if (o.cycles !== 8'd3) begin errors++; $display("FAIL branch_latency[%0d] got=%0d want=3", t, o.cycles); end
      exp_instret++;
    end
  endtask

  task automatic test_random;
    logic [4:0] ops [9];
    obs_t o, e;
    logic [31:0] r, ins;
    int fw, mw;
    logic bt;
    ops = '{5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000, 5'b11011, 5'b11001, 5'b01101, 5'b00101};
    idle_kick(32'h0);
    for (int n = 0; n < 40; n++) begin
      r   = $urandom();
      ins = {r[31:7], ops[$urandom_range(8)], 2'b11};
      fw  = $urandom_range(0, 4);
      mw  = $urandom_range(0, 4);
      bt  = 1'($urandom_range(0, 1));
      run_instr(ins, fw, mw, bt, n == 39, o);
      e = model(ins, fw, mw, bt);
      checks++;
      if (o !== e) begin errors++; $display("FAIL random[%0d] ins=%h fw=%0d mw=%0d got=%h want=%h", n, ins, fw, mw, o, e); end
      checks++;
      if (bus.instret !== exp_instret) begin errors++; $display("FAIL random_instret[%0d] got=%0d want=%0d", n, bus.instret, exp_instret); end
      exp_instret++;
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.instret !== exp_instret || bus.state_dbg !== ST_IDLE) begin
      errors++; $display("FAIL random_end instret=%0d state=%0d want %0d/%0d", bus.instret, bus.state_dbg, exp_instret, ST_IDLE);
    end
  endtask

  task automatic test_illegal;
    state_e exp_st [3];
    exp_st = '{ST_FETCH, ST_DECODE, ST_FAULT};
    idle_kick(32'h0000007F);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.en = 1'b0;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.state_dbg !== exp_st[i]) begin errors++; $display("FAIL illegal_state[%0d] got=%0d want=%0d", i, bus.state_dbg, exp_st[i]); end
    end
    bus.en = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({bus.state_dbg, bus.illegal, bus.timeout} !== {ST_FAULT, 2'b10}) begin
      errors++; $display("FAIL illegal_hold state=%0d flags=%b want %0d/10", bus.state_dbg, {bus.illegal, bus.timeout}, ST_FAULT);
    end
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write, bus.reg_write, bus.retire} !== 6'b0) begin
      errors++; $display("FAIL fault_strobes got=%b want=000000",
        {bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write, bus.reg_write, bus.retire});
    end
    @(posedge clk); #1;
    bus.en = 1'b0;
    bus.fault_clr = 1'b1;
    @(posedge clk); #1;
    bus.fault_clr = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.state_dbg, bus.illegal, bus.timeout} !== {ST_IDLE, 2'b00} || bus.instret !== exp_instret) begin
      errors++; $display("FAIL illegal_clear state=%0d flags=%b instret=%0d want %0d/00/%0d",
        bus.state_dbg, {bus.illegal, bus.timeout}, bus.instret, ST_IDLE, exp_instret);
    end
  endtask

  task automatic test_timeout;
    int bad;
    bad = 0;
    idle_kick(32'h002081B3);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      bus.en = 1'b0;
      bus.mem_ready = 1'b0;
      @(negedge clk);
      if (bus.state_dbg !== ST_FETCH || bus.timeout !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL timeout_wait bad_cycles=%0d want=0", bad); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({bus.state_dbg, bus.timeout, bus.illegal, bus.mem_req} !== {ST_FAULT, 3'b100}) begin
      errors++; $display("FAIL timeout_fault got=%b want=%b",
        {bus.state_dbg, bus.timeout, bus.illegal, bus.mem_req}, {ST_FAULT, 3'b100});
    end
    @(posedge clk); #1;
    bus.fault_clr = 1'b1;
    @(posedge clk); #1;
    bus.fault_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.state_dbg !== ST_IDLE || bus.timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_clear state=%0d timeout=%b want %0d/0", bus.state_dbg, bus.timeout, ST_IDLE);
    end
  endtask

  task automatic test_ready_on_limit;
    idle_kick(32'h002081B3);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      bus.en = 1'b0;
      bus.mem_ready = (k == 16);
      @(negedge clk);
    end
    checks++;
    if (bus.ir_write !== 1'b1) begin errors++; $display("FAIL limit_ready ir_write=%b want=1", bus.ir_write); end
    @(posedge clk); #1;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.state_dbg !== ST_DECODE || bus.timeout !== 1'b0) begin
      errors++; $display("FAIL limit_decode state=%0d timeout=%b want %0d/0", bus.state_dbg, bus.timeout, ST_DECODE);
    end
    repeat (2) begin @(posedge clk); #1; @(negedge clk); end
    checks++;
    if (bus.retire !== 1'b1) begin errors++; $display("FAIL limit_retire got=%b want=1", bus.retire); end
    exp_instret++;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.instret !== exp_instret) begin errors++; $display("FAIL limit_instret got=%0d want=%0d", bus.instret, exp_instret); end
  endtask

  task automatic test_reset_mid_mem;
    idle_kick(32'h0000A183);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.en = 1'b0;
      bus.mem_ready = (i == 0);
      @(negedge clk);
    end
    checks++;
    if (bus.state_dbg !== ST_MEM || bus.instret !== exp_instret) begin
      errors++; $display("FAIL pre_reset state=%0d instret=%0d want %0d/%0d", bus.state_dbg, bus.instret, ST_MEM, exp_instret);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.state_dbg, bus.mem_req, bus.retire} !== {ST_IDLE, 2'b00}) begin
      errors++; $display("FAIL async_reset got=%b want=%b", {bus.state_dbg, bus.mem_req, bus.retire}, {ST_IDLE, 2'b00});
    end
    exp_instret = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.state_dbg !== ST_IDLE || bus.instret !== exp_instret) begin
      errors++; $display("FAIL post_reset state=%0d instret=%0d want %0d/%0d", bus.state_dbg, bus.instret, ST_IDLE, exp_instret);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.instr = '0;
    bus.mem_ready = 1'b0;
    bus.branch_taken = 1'b0;
    bus.fault_clr = 1'b0;
    test_reset();
    test_rtype_sequence();
    test_load_wait();
    test_store();
    test_branch();
    test_random();
    test_illegal();
    test_timeout();
    test_ready_on_limit();
    test_reset_mid_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
